// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: CDB tag/data widths, the "no producer" tag and
// the buffered result entry type used by the broadcaster.
package tomasulo_pkg;

  localparam int LABEL_W = 5;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = LABEL_W + DATA_W;

  localparam logic [LABEL_W-1:0] NO_LABEL = '0;

  typedef struct packed {
    logic [LABEL_W-1:0] label;
    logic [DATA_W-1:0]  data;
  } cdb_entry_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Single-source synchronous result FIFO. Push into a full FIFO and pop from an
// empty one are ignored; full/empty decode from the registered count only.
module result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: buffers per-source results and drives one registered
// broadcast per cycle, chosen round-robin among the non-empty source FIFOs.
module cdb_broadcaster
  import tomasulo_pkg::*;
#(
  parameter int N_SRC      = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         srcValid,
  input  logic [N_SRC*LABEL_W-1:0] srcLabel,
  input  logic [N_SRC*DATA_W-1:0]  srcData,
  output logic [N_SRC-1:0]         srcReady,
  output logic                     BCEN,
  output logic [LABEL_W-1:0]       BClabel,
  output logic [DATA_W-1:0]        BCdata,
  output logic                     protoErr
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]   empty;
  logic [N_SRC-1:0]   full;
  logic [N_SRC-1:0]   push;
  logic [N_SRC-1:0]   pop_d;
  cdb_entry_t         head [N_SRC];

  logic [PTR_W-1:0]   rr_q, rr_d;
  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] bclabel_q, bclabel_d;
  logic [DATA_W-1:0]  bcdata_q, bcdata_d;
  logic               proto_err_q, proto_err_d;
  int                 idx;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    cdb_entry_t din_w;

    assign din_w   = {srcLabel[LABEL_W*g +: LABEL_W], srcData[DATA_W*g +: DATA_W]};
    // Tag-0 results are accepted from the source but never stored.
    assign push[g] = srcValid[g] && !full[g] && (srcLabel[LABEL_W*g +: LABEL_W] != NO_LABEL);

    result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .din   (din_w),
      .pop   (pop_d[g]),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  assign srcReady = ~full;

  always_comb begin
    rr_d        = rr_q;
    bcen_d      = 1'b0;
    bclabel_d   = '0;
    bcdata_d    = '0;
    pop_d       = '0;
    proto_err_d = proto_err_q;
    idx         = 0;

    // Scanning offsets high to low lets the closest hit to rr_q win last.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % N_SRC;
      if (!empty[idx]) begin
        bcen_d     = 1'b1;
        bclabel_d  = head[idx].label;
        bcdata_d   = head[idx].data;
        pop_d      = '0;
        pop_d[idx] = 1'b1;
        rr_d       = PTR_W'(rr_next(idx, N_SRC));
      end
    end

    for (int i = 0; i < N_SRC; i++) begin
      if (srcValid[i] && !full[i] && (srcLabel[LABEL_W*i +: LABEL_W] == NO_LABEL))
        proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      bcen_q      <= 1'b0;
      bclabel_q   <= '0;
      bcdata_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      bcen_q      <= bcen_d;
      bclabel_q   <= bclabel_d;
      bcdata_q    <= bcdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign BCEN     = bcen_q;
  assign BClabel  = bclabel_q;
  assign BCdata   = bcdata_q;
  assign protoErr = proto_err_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios plus randomized
// traffic compared against a queue-based model of the broadcast rules.
module tb_cdb_broadcaster;

  localparam int N = 3;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  srcValid;
  logic [14:0] srcLabel;
  logic [95:0] srcData;
  logic [2:0]  srcReady;
  logic        BCEN;
  logic [4:0]  BClabel;
  logic [31:0] BCdata;
  logic        protoErr;

  cdb_broadcaster #(.N_SRC(N), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .srcValid (srcValid),
    .srcLabel (srcLabel),
    .srcData  (srcData),
    .srcReady (srcReady),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata),
    .protoErr (protoErr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [36:0] mq [N][$];
  int          mp;
  logic        m_bcen;
  logic [4:0]  m_lbl;
  logic [31:0] m_dat;
  logic        m_perr;
  logic [2:0]  m_acc;

  // Source-side retry state
  logic        pend_v [N];
  logic [4:0]  pend_l [N];
  logic [31:0] pend_d [N];
  logic        bp_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] pkl(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [95:0] pkd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      pend_v[i] = 1'b0;
    end
    mp = 0; m_bcen = 1'b0; m_lbl = '0; m_dat = '0; m_perr = 1'b0; m_acc = '0;
  endtask

  task automatic model_edge(input logic [2:0] v, input logic [14:0] l, input logic [95:0] d);
    logic [2:0]  rdy;
    logic [36:0] e;
    int          w;
    int          s;
    rdy = model_ready();
    w = -1;
    for (int k = 0; k < N; k++) begin
      s = (mp + k) % N;
      if (w < 0 && mq[s].size() > 0) w = s;
    end
    if (w >= 0) begin
      e = mq[w].pop_front();
      m_bcen = 1'b1; m_lbl = e[36:32]; m_dat = e[31:0];
      mp = (w + 1) % N;
    end else begin
      m_bcen = 1'b0; m_lbl = '0; m_dat = '0;
    end
    m_acc = v & rdy;
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        if (l[5*i +: 5] == 5'd0) m_perr = 1'b1;
        else mq[i].push_back({l[5*i +: 5], d[32*i +: 32]});
      end
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, outputs after.
  task automatic cycle(input logic [2:0] v, input logic [14:0] l, input logic [95:0] d);
    srcValid = v; srcLabel = l; srcData = d;
    #1;
    check("srcReady", 64'(srcReady), 64'(model_ready()));
    @(posedge clk);
    model_edge(v, l, d);
    @(negedge clk);
    check("BCEN", 64'(BCEN), 64'(m_bcen));
    check("BClabel", 64'(BClabel), 64'(m_lbl));
    check("BCdata", 64'(BCdata), 64'(m_dat));
    check("protoErr", 64'(protoErr), 64'(m_perr));
  endtask

  task automatic idle();
    cycle(3'b000, '0, '0);
  endtask

  // Assert reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    srcValid = '0;
    #1;
    check("rst_BCEN", 64'(BCEN), 64'(0));
    check("rst_BClabel", 64'(BClabel), 64'(0));
    check("rst_BCdata", 64'(BCdata), 64'(0));
    check("rst_protoErr", 64'(protoErr), 64'(0));
    check("rst_srcReady", 64'(srcReady), 64'(3'b111));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_traffic(input int ncyc, input int pct, input bit allow_zero, input bit chk_rot);
    logic [2:0]  v;
    logic [14:0] l;
    logic [95:0] d;
    int          prev_src;
    int          cur_src;
    prev_src = -1;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && ($urandom_range(99) < pct)) begin
          pend_v[i] = 1'b1;
          pend_l[i] = 5'(8 * i + $urandom_range(1, 7));
          if (allow_zero && $urandom_range(49) == 0) pend_l[i] = 5'd0;
          pend_d[i] = $urandom();
        end
        v[i]          = pend_v[i];
        l[5*i +: 5]   = pend_l[i];
        d[32*i +: 32] = pend_d[i];
      end
      cycle(v, l, d);
      for (int i = 0; i < N; i++) if (m_acc[i]) pend_v[i] = 1'b0;
      if (srcReady != 3'b111) bp_seen = 1'b1;
      if (chk_rot && BCEN) begin
        cur_src = (int'(BClabel) - 1) / 8;
        if (prev_src >= 0) check("rotate", 64'(cur_src), 64'((prev_src + 1) % N));
        prev_src = cur_src;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    srcValid = '0; srcLabel = '0; srcData = '0;
    bp_seen = 1'b0;
    model_reset();

    // 1: reset state, at power-up and asserted mid-cycle
    @(negedge clk);
    check("por_BCEN", 64'(BCEN), 64'(0));
    check("por_srcReady", 64'(srcReady), 64'(3'b111));
    rst = 1'b0;
    do_reset();

    // 2: single result, one-cycle broadcast
    cycle(3'b001, pkl(5'd2, 5'd0, 5'd0), pkd(32'd32, 32'd0, 32'd0));
    check("t2_first", 64'(BCEN), 64'(0));
    idle();
    check("t2_bcen", 64'(BCEN), 64'(1));
    check("t2_lbl", 64'(BClabel), 64'(2));
    check("t2_dat", 64'(BCdata), 64'(32));
    idle();
    check("t2_once", 64'(BCEN), 64'(0));

    // 3: contention from p=0, then src1/src2 together
    do_reset();
    cycle(3'b111, pkl(5'd3, 5'd4, 5'd5), pkd(32'd100, 32'd200, 32'd300));
    idle(); check("t3_a", 64'({BCEN, BClabel, BCdata}), 64'({1'b1, 5'd3, 32'd100}));
    idle(); check("t3_b", 64'({BCEN, BClabel, BCdata}), 64'({1'b1, 5'd4, 32'd200}));
    idle(); check("t3_c", 64'({BCEN, BClabel, BCdata}), 64'({1'b1, 5'd5, 32'd300}));
    cycle(3'b110, pkl(5'd0, 5'd6, 5'd7), pkd(32'd0, 32'd1, 32'd2));
    check("t3_gap", 64'(BCEN), 64'(0));
    idle(); check("t3_d", 64'({BCEN, BClabel}), 64'({1'b1, 5'd6}));
    idle(); check("t3_e", 64'({BCEN, BClabel}), 64'({1'b1, 5'd7}));
    idle(); check("t3_end", 64'(BCEN), 64'(0));

    // 4: back-pressure with every source pushing every cycle
    do_reset();
    bp_seen = 1'b0;
    run_traffic(12, 100, 1'b0, 1'b1);
    check("t4_bp_seen", 64'(bp_seen), 64'(1));
    for (int c = 0; c < 8; c++) idle();
    check("t4_drained", 64'(BCEN), 64'(0));

    // 5: tag 0 is consumed, flags protoErr, never broadcast
    do_reset();
    cycle(3'b100, pkl(5'd0, 5'd0, 5'd0), pkd(32'd0, 32'd0, 32'd99));
    check("t5_perr", 64'(protoErr), 64'(1));
    for (int c = 0; c < 3; c++) begin
      idle();
      check("t5_nobc", 64'(BCEN), 64'(0));
      check("t5_sticky", 64'(protoErr), 64'(1));
    end
    do_reset();
    idle();
    check("t5_cleared", 64'(protoErr), 64'(0));

    // 6: reset with results buffered discards them all
    do_reset();
    cycle(3'b111, pkl(5'd1, 5'd9, 5'd17), pkd(32'd11, 32'd12, 32'd13));
    cycle(3'b111, pkl(5'd2, 5'd10, 5'd18), pkd(32'd21, 32'd22, 32'd23));
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      check("t6_stale", 64'(BCEN), 64'(0));
    end
    cycle(3'b010, pkl(5'd0, 5'd12, 5'd0), pkd(32'd0, 32'd77, 32'd0));
    idle();
    check("t6_new", 64'({BCEN, BClabel, BCdata}), 64'({1'b1, 5'd12, 32'd77}));

    // Randomized traffic against the model, with a reset in the middle
    do_reset();
    run_traffic(400, 60, 1'b1, 1'b0);
    do_reset();
    run_traffic(200, 90, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
